l2_mem_burst: RTL and testbench
===============================

// Module: l2_mem_burst
// PURPOSE
// - Memory-side line transfer engine directly downstream of the L2 cache controller.
// - Turns one controller line request (mem_r fetch / mem_w write-back) into a WORDS-beat burst on a word-wide req/ack memory bus.
// - Returns a one-cycle mem_ready pulse when the whole line has moved.
// - Read data is returned as a full line on line_rdata for the cache data array.
// PARAMETERS
// ADDR_W       32   byte-address width
// DATA_W       32   memory bus word width (multiple of 8)
// WORDS        4    words per cache line (power of 2, >=2)
// TIMEOUT_CYC  255  max cycles waiting for m_ack on one beat (used only with MEM_TIMEOUT_EN)
// PORTS
// clk         in   1               clock
// rst         in   1               synchronous, active-high reset
// mem_r       in   1               line fetch request, held until mem_ready
// mem_w       in   1               line write-back request, held until mem_ready
// line_addr   in   ADDR_W          byte address of line; low OFF=log2(WORDS*DATA_W/8) bits ignored
// line_wdata  in   WORDS*DATA_W    write-back line, word i at [i*DATA_W +: DATA_W]
// line_rdata  out  WORDS*DATA_W    fetched line, same packing
// mem_ready   out  1               one-cycle pulse: transfer finished (or aborted)
// mem_err     out  1               one-cycle pulse with mem_ready on timeout abort; constant 0 otherwise
// m_req       out  1               bus beat request
// m_we        out  1               bus beat is a write
// m_addr      out  ADDR_W          bus beat byte address
// m_wdata     out  DATA_W          bus write word
// m_rdata     in   DATA_W          bus read word, valid with m_ack
// m_ack       in   1               beat accepted/complete; ignored when m_req=0
// BEHAVIOUR
// - Reset: all outputs 0, line_rdata 0, beat=0, state IDLE.
// - States: IDLE, BUSY, DONE; all outputs registered or decoded from state/registers.
// - IDLE:
//   - on mem_w|mem_r: latch base={line_addr[ADDR_W-1:OFF],OFF'b0}, we=mem_w, snapshot line_wdata, beat=0.
//   - if read, clear line_rdata; go to BUSY.
//   - mem_w has priority if both are high.
// - BUSY: m_req=1, m_we=we, m_addr=base+beat*(DATA_W/8), m_wdata=snapshot word[beat].
//   - on m_ack, read: line_rdata word[beat] <= m_rdata.
//   - on m_ack with beat==WORDS-1: go to DONE.
//   - on m_ack otherwise: beat++ and stay in BUSY (back-to-back beats allowed, m_req stays 1).
//   - no m_ack: hold all bus outputs stable.
// - DONE: m_req=0; mem_ready=1 for exactly this cycle; go to IDLE.
// - Latency with zero-wait acks:
//   - request first seen at edge N; BUSY cycles N+1..N+WORDS; mem_ready in cycle N+WORDS+1.
// - Request levels are sampled only in IDLE.
//   - Dropping mem_r/mem_w mid-burst has no effect; the burst completes.
//   - A request still high in IDLE after DONE starts a new burst.
// - line_rdata holds its value after a read until the next read starts; write bursts never modify it.
// - Address wrap: base+offset wraps modulo 2^ADDR_W; a line never crosses a line boundary.
// - rst mid-burst: next edge forces IDLE and m_req=0; no mem_ready; partial line_rdata cleared.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined:
//   - per-beat wait counter cleared at BUSY entry and on each m_ack.
//   - counter reaching TIMEOUT_CYC with no m_ack: drop m_req, go to DONE; mem_ready=1 and mem_err=1 together.
//   - unreceived read words stay 0.
// - MEM_TIMEOUT_EN undefined: no counter; BUSY waits forever; mem_err tied 0.
// TESTING
// - Read, defaults, line_addr=0x0000_1234, m_ack always 1, m_rdata=0xA000_0000+beat:
//   - m_addr 0x1230,0x1234,0x1238,0x123C; m_we=0.
//   - mem_ready 5 cycles after request edge.
//   - line_rdata=0xA0000003_A0000002_A0000001_A0000000.
// - Write, line_wdata=0x44444444_33333333_22222222_11111111, ack 2 cycles after each req:
//   - m_we=1; m_wdata 0x11111111..0x44444444 in order, stable while waiting.
//   - mem_ready once after 4th ack; line_rdata unchanged.
// - mem_r=mem_w=1: burst is a write (m_we=1); line_rdata not cleared.
// - rst asserted after 2nd ack of a read: m_req=0 next cycle, line_rdata=0, no mem_ready; new mem_r restarts at beat 0.
// - mem_r held high through DONE: second burst starts; m_req low exactly for the DONE and IDLE cycles.
// - MEM_TIMEOUT_EN, TIMEOUT_CYC=8, m_ack never asserted:
//   - mem_ready=mem_err=1 for one cycle after 8 BUSY cycles; line_rdata=0.
//   - without the macro: m_req stays 1 for 100 cycles, no mem_ready.

Source files
------------

// File: rtl/l2_mem_burst.sv
// Line transfer engine between the L2 controller and a word-wide req/ack memory bus.
// Optional per-beat ack timeout is compiled in when MEM_TIMEOUT_EN is defined.
module l2_mem_burst #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WORDS       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_r,
  input  logic                    mem_w,
  input  logic [ADDR_W-1:0]       line_addr,
  input  logic [WORDS*DATA_W-1:0] line_wdata,
  output logic [WORDS*DATA_W-1:0] line_rdata,
  output logic                    mem_ready,
  output logic                    mem_err,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_W-1:0]       m_addr,
  output logic [DATA_W-1:0]       m_wdata,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic                    m_ack
);

  localparam int BYTES      = DATA_W / 8;
  localparam int LINE_BYTES = WORDS * BYTES;
  localparam int BW         = $clog2(WORDS);
  localparam int BSH        = $clog2(BYTES);

  // Bus handshake: a beat completes on any rising clk edge where m_req and
  // m_ack are both high; while m_ack is low every bus output is held stable.

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_next;
  logic [BW-1:0]           beat;
  logic [ADDR_W-1:0]       base;
  logic                    we;
  logic [WORDS*DATA_W-1:0] wsnap;
  logic                    start;
  logic                    last_beat;
  logic                    timed_out;

  assign start     = (state == IDLE) && (mem_r || mem_w);
  assign last_beat = (beat == BW'(WORDS - 1));

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt;
  logic          err;

  assign timed_out = (state == BUSY) && !m_ack && (wait_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (start) err <= 1'b0;
        end
        BUSY: begin
          if (m_ack) wait_cnt <= '0;
          else       wait_cnt <= wait_cnt + 1'b1;
          if (timed_out) err <= 1'b1;
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  assign mem_err = (state == DONE) && err;
`else
  assign timed_out = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mem_r || mem_w) state_next = BUSY;
      BUSY: begin
        if (m_ack) begin
          if (last_beat) state_next = DONE;
        end else if (timed_out) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request capture in IDLE, word transfer in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat       <= '0;
      base       <= '0;
      we         <= 1'b0;
      wsnap      <= '0;
      line_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Masking (rather than slicing) keeps the ignored offset bits in use.
            base  <= line_addr & ~ADDR_W'(LINE_BYTES - 1);
            we    <= mem_w;
            wsnap <= line_wdata;
            beat  <= '0;
            if (!mem_w) line_rdata <= '0;
          end
        end
        BUSY: begin
          if (m_ack) begin
            if (!we) line_rdata[int'(beat)*DATA_W +: DATA_W] <= m_rdata;
            beat <= beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line base is aligned, so the beat offset never carries out of the line.
  assign m_req     = (state == BUSY);
  assign m_we      = (state == BUSY) && we;
  assign m_addr    = base + (ADDR_W'(beat) << BSH);
  assign m_wdata   = wsnap[int'(beat)*DATA_W +: DATA_W];
  assign mem_ready = (state == DONE);

endmodule

// File: tb/tb_l2_mem_burst.sv
// Directed bench for l2_mem_burst: bus responder/monitor with beat scoreboard,
// plus read, write, priority, wrap, reset, back-to-back and timeout scenarios.
module tb_l2_mem_burst;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam int LW     = WORDS * DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_r, mem_w;
  logic [ADDR_W-1:0] line_addr;
  logic [LW-1:0]     line_wdata;
  logic [LW-1:0]     line_rdata;
  logic              mem_ready, mem_err;
  logic              m_req, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;

  l2_mem_burst #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .mem_r(mem_r), .mem_w(mem_w),
    .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(line_rdata),
    .mem_ready(mem_ready), .mem_err(mem_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_wdata_q[$];
  logic              exp_we     = 1'b0;
  logic              ack_en     = 1'b1;
  int                ack_delay  = 0;
  logic [DATA_W-1:0] rdata_base = '0;
  int                ready_cnt  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_line(input logic [DATA_W-1:0] base, input logic [LW-1:0] wd);
    for (int i = 0; i < WORDS; i++) begin
      exp_addr_q.push_back(base + DATA_W'(i * 4));
      exp_wdata_q.push_back(wd[i*DATA_W +: DATA_W]);
    end
  endtask

  // Responder and monitor share one process so ack and logging never race.
  initial begin : responder
    int                wait_cnt;
    logic              prev_wait;
    logic [DATA_W-1:0] prev_addr, prev_wdata, ea, ew;
    wait_cnt   = 0;
    prev_wait  = 1'b0;
    prev_addr  = '0;
    prev_wdata = '0;
    m_ack      = 1'b0;
    m_rdata    = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) ready_cnt++;
      if (prev_wait && m_req) begin
        check("hold_addr", m_addr, prev_addr);
        check("hold_wdata", m_wdata, prev_wdata);
      end
      if (!m_req) begin
        m_ack    = 1'b0;
        wait_cnt = 0;
      end else if (ack_en && wait_cnt >= ack_delay) begin
        m_ack    = 1'b1;
        wait_cnt = 0;
      end else begin
        m_ack    = 1'b0;
        wait_cnt++;
      end
      m_rdata = rdata_base + DATA_W'(m_addr[3:2]);
      if (m_req && m_ack) begin
        if (exp_addr_q.size() == 0) begin
          check("beat_unexpected", 32'(exp_addr_q.size()), 1);
        end else begin
          ea = exp_addr_q.pop_front();
          ew = exp_wdata_q.pop_front();
          check("beat_addr", m_addr, ea);
          check("beat_we", m_we, exp_we);
          if (exp_we) check("beat_wdata", m_wdata, ew);
        end
      end
      prev_wait  = m_req && !m_ack;
      prev_addr  = m_addr;
      prev_wdata = m_wdata;
    end
  end

  // Presents a request at a negedge and holds it until mem_ready (bounded).
  // Inputs are scrambled after the first edge to prove the request is snapshotted.
  task automatic do_req(input logic r, input logic w, input logic [ADDR_W-1:0] addr,
                        input logic [LW-1:0] wd, output int cyc, output logic err);
    mem_r      = r;
    mem_w      = w;
    line_addr  = addr;
    line_wdata = wd;
    cyc        = 0;
    err        = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        line_wdata = ~wd;
        line_addr  = ~addr;
      end
      if (mem_ready) begin
        err = mem_err;
        break;
      end
    end
    mem_r = 1'b0;
    mem_w = 1'b0;
  endtask

  localparam logic [LW-1:0] LINE_A = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [LW-1:0] WLINE  = 128'h44444444_33333333_22222222_11111111;

  initial begin : main
    int   cyc, r0, low, n_rdy, hi;
    logic err, seen_req;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    line_addr  = '0;
    line_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_line_rdata", line_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read
    ack_en = 1'b1; ack_delay = 0; rdata_base = 32'hA000_0000; exp_we = 1'b0;
    push_line(32'h0000_1230, '0);
    r0 = ready_cnt;
    do_req(1'b1, 1'b0, 32'h0000_1234, '0, cyc, err);
    check("rd_latency", cyc, 5);
    check("rd_err", err, 0);
    check("rd_line", line_rdata, LINE_A);
    repeat (2) @(negedge clk);
    check("rd_ready_cnt", ready_cnt - r0, 1);

    // Write with two wait cycles per beat
    ack_delay = 2; exp_we = 1'b1;
    push_line(32'h2000_0040, WLINE);
    r0 = ready_cnt;
    do_req(1'b0, 1'b1, 32'h2000_0048, WLINE, cyc, err);
    check("wr_latency", cyc, 13);
    check("wr_line_kept", line_rdata, LINE_A);
    repeat (2) @(negedge clk);
    check("wr_ready_cnt", ready_cnt - r0, 1);

    // Both requests high: write wins, line_rdata untouched
    ack_delay = 0; exp_we = 1'b1;
    push_line(32'h0000_0F00, 128'h88888888_77777777_66666666_55555555);
    do_req(1'b1, 1'b1, 32'h0000_0F08, 128'h88888888_77777777_66666666_55555555, cyc, err);
    check("both_latency", cyc, 5);
    check("both_line_kept", line_rdata, LINE_A);
    @(negedge clk);

    // Read of the topmost line: addresses stay inside it
    rdata_base = 32'hB000_0000; exp_we = 1'b0;
    push_line(32'hFFFF_FFF0, '0);
    do_req(1'b1, 1'b0, 32'hFFFF_FFFC, '0, cyc, err);
    check("wrap_latency", cyc, 5);
    check("wrap_line", line_rdata, 128'hB0000003_B0000002_B0000001_B0000000);
    @(negedge clk);

    // Reset after the second ack of a read
    rdata_base = 32'hC000_0000;
    exp_addr_q.push_back(32'h0000_0100); exp_wdata_q.push_back('0);
    exp_addr_q.push_back(32'h0000_0104); exp_wdata_q.push_back('0);
    exp_addr_q.push_back(32'h0000_0108); exp_wdata_q.push_back('0);
    r0 = ready_cnt;
    mem_r = 1'b1; line_addr = 32'h0000_0104;
    repeat (3) @(negedge clk);
    rst = 1'b1; mem_r = 1'b0;
    @(negedge clk);
    check("rstmid_m_req", m_req, 0);
    check("rstmid_line", line_rdata, 0);
    check("rstmid_ready", mem_ready, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_ready_cnt", ready_cnt - r0, 0);
    push_line(32'h0000_0100, '0);
    do_req(1'b1, 1'b0, 32'h0000_0100, '0, cyc, err);
    check("restart_latency", cyc, 5);
    check("restart_line", line_rdata, 128'hC0000003_C0000002_C0000001_C0000000);
    @(negedge clk);

    // mem_r held through DONE: second burst follows after DONE+IDLE
    rdata_base = 32'hD000_0000;
    push_line(32'h0000_3000, '0);
    push_line(32'h0000_3000, '0);
    mem_r = 1'b1; line_addr = 32'h0000_3000;
    seen_req = 1'b0; low = 0; n_rdy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_ready) n_rdy++;
      if (n_rdy == 2) break;
      if (seen_req && !m_req) low++;
      if (m_req) seen_req = 1'b1;
    end
    mem_r = 1'b0;
    check("b2b_ready_cnt", n_rdy, 2);
    check("b2b_req_low", low, 2);
    check("b2b_line", line_rdata, 128'hD0000003_D0000002_D0000001_D0000000);
    @(negedge clk);

    // Memory never acks
    ack_en = 1'b0;
`ifdef MEM_TIMEOUT_EN
    do_req(1'b1, 1'b0, 32'h0000_0500, '0, cyc, err);
    check("to_latency", cyc, 9);
    check("to_err", err, 1);
    check("to_line", line_rdata, 0);
    @(negedge clk);
    check("to_ready_pulse", mem_ready, 0);
    check("to_err_pulse", mem_err, 0);
`else
    r0 = ready_cnt;
    mem_r = 1'b1; line_addr = 32'h0000_0500;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_req) hi++;
    end
    check("noto_req_high", hi, 100);
    check("noto_ready_cnt", ready_cnt - r0, 0);
    check("noto_err", mem_err, 0);
    rst = 1'b1; mem_r = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("noto_rst_req", m_req, 0);
`endif
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    check("beats_left", exp_addr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
